// File: rtl/mdu_seq_unit_if.sv
// Bus between the E stage and the multiply/divide unit.
// The E stage drives the op code and the forwarded operands; the MDU returns
// the HI/LO read data and its start/busy status to the stall unit.
interface mdu_seq_unit_if;
   logic [4:0]  MDUType;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] MDUO;
   logic        start;
   logic        busy;

   modport master (
      output MDUType, A, B,
      input  MDUO, start, busy
   );

   modport slave (
      input  MDUType, A, B,
      output MDUO, start, busy
   );
endinterface

// File: rtl/mdu_seq_unit.sv
// Multi-cycle multiply/divide unit for the E stage of a 5-stage MIPS pipeline.
// Owns HI/LO. A mult/div-class op computes its result at the start edge into
// pend_hi/pend_lo, then a countdown hides the latency; HI/LO are committed on
// the edge where the counter reaches zero.
//
// Handshake: an op is accepted on a rising edge exactly when start==1, and
// start is high only when MDUType is a mult/div-class op and busy==0. There is
// no backpressure on the op itself; any mult/div-class op presented while
// busy==1 is dropped, so the stall unit must hold it in D while start|busy.
//
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (codes
// 9-12) as multiply-accumulate ops. Undefined, those codes behave as "none".
module mdu_seq_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic          clk,
   input  logic          reset,
   mdu_seq_unit_if.slave bus
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [4:0] OP_MULT  = 5'd1;
   localparam logic [4:0] OP_MULTU = 5'd2;
   localparam logic [4:0] OP_DIV   = 5'd3;
   localparam logic [4:0] OP_DIVU  = 5'd4;
   localparam logic [4:0] OP_MFHI  = 5'd5;
   localparam logic [4:0] OP_MFLO  = 5'd6;
   localparam logic [4:0] OP_MTHI  = 5'd7;
   localparam logic [4:0] OP_MTLO  = 5'd8;
`ifdef MDU_MADD_EN
   localparam logic [4:0] OP_MADD  = 5'd9;
   localparam logic [4:0] OP_MADDU = 5'd10;
   localparam logic [4:0] OP_MSUB  = 5'd11;
   localparam logic [4:0] OP_MSUBU = 5'd12;
`endif

   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pend_hi_q, pend_hi_d;
   logic [31:0]      pend_lo_q, pend_lo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        is_mul;
   logic        is_div;
   logic        is_madd;
   logic        busy;
   logic        start;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [63:0] div_res;
   logic [63:0] mul_res;

   // Decode the op class and derive start/busy.
   always_comb begin
      is_mul  = (bus.MDUType == OP_MULT) || (bus.MDUType == OP_MULTU);
      is_div  = (bus.MDUType == OP_DIV)  || (bus.MDUType == OP_DIVU);
`ifdef MDU_MADD_EN
      is_madd = (bus.MDUType == OP_MADD) || (bus.MDUType == OP_MADDU) ||
                (bus.MDUType == OP_MSUB) || (bus.MDUType == OP_MSUBU);
`else
      is_madd = 1'b0;
`endif
      busy  = (cnt_q != '0);
      start = (is_mul || is_div || is_madd) && !busy;
   end

   // 64-bit products: low 64 bits of sign/zero-extended operands.
   always_comb begin
      prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
      prod_u = {32'b0, bus.A} * {32'b0, bus.B};
   end

   // Select the multiply-class result, including the accumulate forms.
   always_comb begin
      mul_res = (bus.MDUType == OP_MULT) ? prod_s : prod_u;
`ifdef MDU_MADD_EN
      case (bus.MDUType)
         OP_MADD:  mul_res = {hi_q, lo_q} + prod_s;
         OP_MADDU: mul_res = {hi_q, lo_q} + prod_u;
         OP_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
         OP_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
         default:  ;
      endcase
`endif
   end

   // Division on magnitudes, then fix signs. Working on magnitudes makes
   // 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
   // A zero divisor re-commits the current HI/LO, which cannot change while
   // busy, so the op leaves them untouched.
   always_comb begin
      logic        sgn;
      logic        a_neg;
      logic        b_neg;
      logic [31:0] a_mag;
      logic [31:0] b_mag;
      logic [31:0] b_safe;
      logic [31:0] q_mag;
      logic [31:0] r_mag;
      sgn    = (bus.MDUType == OP_DIV);
      a_neg  = sgn && bus.A[31];
      b_neg  = sgn && bus.B[31];
      a_mag  = a_neg ? (32'd0 - bus.A) : bus.A;
      b_mag  = b_neg ? (32'd0 - bus.B) : bus.B;
      b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag  = a_mag / b_safe;
      r_mag  = a_mag % b_safe;
      if (bus.B == 32'd0) begin
         div_res = {hi_q, lo_q};
      end else begin
         div_res[63:32] = a_neg ? (32'd0 - r_mag) : r_mag;
         div_res[31:0]  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      end
   end

   // Next-state: start loads pend and the counter, countdown commits HI/LO,
   // mthi/mtlo write directly when idle.
   always_comb begin
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      cnt_d     = cnt_q;
      if (busy) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (start) begin
         if (is_div) begin
            {pend_hi_d, pend_lo_d} = div_res;
            cnt_d                  = CNT_W'(DIV_CYCLES);
         end else begin
            {pend_hi_d, pend_lo_d} = mul_res;
            cnt_d                  = CNT_W'(MUL_CYCLES);
         end
      end else if (bus.MDUType == OP_MTHI) begin
         hi_d = bus.A;
      end else if (bus.MDUType == OP_MTLO) begin
         lo_d = bus.A;
      end
   end

   // State registers; reset discards any pending result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         cnt_q     <= '0;
      end else begin
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         cnt_q     <= cnt_d;
      end
   end

   // Outputs: status to the stall unit and the mfhi/mflo read port.
   always_comb begin
      bus.start = start;
      bus.busy  = busy;
      case (bus.MDUType)
         OP_MFHI: bus.MDUO = hi_q;
         OP_MFLO: bus.MDUO = lo_q;
         default: bus.MDUO = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_seq_unit.sv
// Directed bench for mdu_seq_unit (MUL_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_seq_unit;

   localparam logic [4:0] OP_NONE  = 5'd0;
   localparam logic [4:0] OP_MULT  = 5'd1;
   localparam logic [4:0] OP_MULTU = 5'd2;
   localparam logic [4:0] OP_DIV   = 5'd3;
   localparam logic [4:0] OP_DIVU  = 5'd4;
   localparam logic [4:0] OP_MFHI  = 5'd5;
   localparam logic [4:0] OP_MFLO  = 5'd6;
   localparam logic [4:0] OP_MTHI  = 5'd7;
   localparam logic [4:0] OP_MTLO  = 5'd8;
   localparam logic [4:0] OP_MADDU = 5'd10;
   localparam logic [4:0] OP_MSUB  = 5'd11;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   mdu_seq_unit_if bus ();

   mdu_seq_unit #(
      .MUL_CYCLES(5),
      .DIV_CYCLES(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.MDUType = op;
      bus.A       = a;
      bus.B       = b;
      #1;
   endtask

   task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      issue(OP_MFHI, 32'd0, 32'd0);
      chk({tag, "_hi"}, bus.MDUO, hi);
      issue(OP_MFLO, 32'd0, 32'd0);
      chk({tag, "_lo"}, bus.MDUO, lo);
      issue(OP_NONE, 32'd0, 32'd0);
   endtask

   // Issue a mult/div op, check start, count busy cycles (bounded).
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_n);
      int n;
      issue(op, a, b);
      chk({tag, "_start"}, 32'(bus.start), 32'd1);
      chk({tag, "_busy_at_t"}, 32'(bus.busy), 32'd0);
      tick();
      issue(OP_NONE, 32'd0, 32'd0);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         tick();
      end
      chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
   endtask

   initial begin
      int n;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.MDUType = OP_NONE;
      bus.A = '0;
      bus.B = '0;
      tick();
      tick();
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_start", 32'(bus.start), 32'd0);
      read_hilo("reset", 32'h0, 32'h0);
      reset = 1'b0;
      tick();

      // mult -2 * 3 = -6
      run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 5);
      read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

      // multu 0xFFFFFFFF * 2
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
      read_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

      // div -7 / 2 -> q=-3, r=-1
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // divu by zero keeps HI/LO, still busy 10 cycles
      run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 10);
      read_hilo("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // overflow case
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
      read_hilo("div_ovf", 32'h0, 32'h8000_0000);

      // divu 100 / 7 -> q=14, r=2
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 10);
      read_hilo("divu", 32'd2, 32'd14);

      // div 7 / -2 -> q=-3, r=1
      run_op("div_pos", OP_DIV, 32'd7, 32'hFFFF_FFFE, 10);
      read_hilo("div_pos", 32'd1, 32'hFFFF_FFFD);

      // mthi / mtlo when idle
      issue(OP_MTHI, 32'h1234_5678, 32'd0);
      chk("mthi_start", 32'(bus.start), 32'd0);
      tick();
      issue(OP_MTLO, 32'hAAAA_5555, 32'd0);
      tick();
      read_hilo("mtx", 32'h1234_5678, 32'hAAAA_5555);

      // mtlo and a second mult while busy are both ignored; mfhi during busy sees old value
      issue(OP_MULT, 32'd3, 32'd4);
      chk("mult34_start", 32'(bus.start), 32'd1);
      tick();
      issue(OP_MTLO, 32'hDEAD_BEEF, 32'd0);
      chk("mtlo_busy_flag", 32'(bus.busy), 32'd1);
      tick();
      issue(OP_MULTU, 32'd5, 32'd5);
      chk("mult_while_busy_start", 32'(bus.start), 32'd0);
      tick();
      issue(OP_MFHI, 32'd0, 32'd0);
      chk("mfhi_during_busy", bus.MDUO, 32'h1234_5678);
      issue(OP_NONE, 32'd0, 32'd0);
      n = 0;
      while (bus.busy && n < 200) begin
         n++;
         tick();
      end
      chk("mult34_drain", 32'(n), 32'd3);
      read_hilo("mult34", 32'd0, 32'd12);

      // reset in the middle of a divide
      issue(OP_MTHI, 32'h11, 32'd0);
      tick();
      issue(OP_MTLO, 32'h22, 32'd0);
      tick();
      issue(OP_DIV, 32'd100, 32'd3);
      tick();
      issue(OP_NONE, 32'd0, 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("pre_reset_busy", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_reset_busy", 32'(bus.busy), 32'd0);
      read_hilo("mid_reset", 32'h0, 32'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) tick();
      chk("post_reset_busy", 32'(bus.busy), 32'd0);
      read_hilo("post_reset", 32'h0, 32'h0);

      // multiply-accumulate codes
      issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
      tick();
`ifdef MDU_MADD_EN
      run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5);
      read_hilo("maddu", 32'd1, 32'd0);
      // {1,0} - (-1 * 1) = 0x1_00000001
      run_op("msub", OP_MSUB, 32'hFFFF_FFFF, 32'd1, 5);
      read_hilo("msub", 32'd1, 32'd1);
`else
      issue(OP_MADDU, 32'd1, 32'd1);
      chk("maddu_off_start", 32'(bus.start), 32'd0);
      chk("maddu_off_mduo", bus.MDUO, 32'd0);
      tick();
      chk("maddu_off_busy", 32'(bus.busy), 32'd0);
      issue(OP_MSUB, 32'd1, 32'd1);
      tick();
      read_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif

      // undefined op codes
      issue(5'd13, 32'd9, 32'd9);
      chk("undef13_start", 32'(bus.start), 32'd0);
      chk("undef13_mduo", bus.MDUO, 32'd0);
      issue(5'd31, 32'd9, 32'd9);
      chk("undef31_mduo", bus.MDUO, 32'd0);
      tick();
      chk("undef_busy", 32'(bus.busy), 32'd0);
      issue(OP_NONE, 32'd0, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
